digit_entry: RTL and testbench

- Operator input front-end for the 4-digit seven-segment display path.
- Debounces the five board pushbuttons (U/D/L/R/C) and lets the user edit a 4-digit decimal value one digit at a time.
- Presents the live value as a 16-bit binary number, suitable as the display driver's number input.
- Emits a one-cycle commit pulse with the final binary value when the centre button is pressed.

---
 rtl/digit_entry.sv | 123 ++++++++++++
 tb/tb_digit_entry.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/digit_entry.sv
// Pushbutton front-end: debounces U/D/L/R/C and edits a 4-digit decimal entry.
// Press pulse arrives DEBOUNCE_CYCLES+3 clocks after a clean raw rising edge.
module digit_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        btnC,
  output logic [15:0] entry_value,
  output logic [1:0]  cursor,
  output logic        commit_valid,
  output logic [15:0] commit_value,
  output logic        busy
);

  // state  | meaning
  // EDIT   | button presses edit digits / move cursor
  // COMMIT | one-cycle commit_valid pulse
  // HOLD   | presses ignored until every button is released
  typedef enum logic [1:0] {
    EDIT   = 2'd0,
    COMMIT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam int BC = 0;
  localparam int BU = 1;
  localparam int BD = 2;
  localparam int BL = 3;
  localparam int BR = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [4:0]        btn_raw;
  logic [4:0]        sync1;
  logic [4:0]        sync2;
  logic [4:0]        stable;
  logic [4:0]        stable_d;
  logic [4:0]        press;
  logic [CNT_W-1:0]  cnt [5];
  logic [3:0]        digit [4];

  assign btn_raw = {btnR, btnL, btnD, btnU, btnC};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      press    <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= EDIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EDIT:    if (press[BC]) state_next = COMMIT;
      COMMIT:  state_next = HOLD;
      HOLD:    if (stable == 5'd0) state_next = EDIT;
      default: state_next = EDIT;
    endcase
  end

  always_comb begin
    commit_valid = (state == COMMIT);
    busy         = (state != EDIT);
  end

  // Priority C > U > D > L > R; losing pulses in the same cycle are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) digit[i] <= '0;
      cursor       <= '0;
      commit_value <= '0;
    end else if (state == EDIT) begin
      if (press[BC]) begin
        commit_value <= entry_value;
      end else if (press[BU]) begin
        digit[cursor] <= (digit[cursor] == 4'd9) ? 4'd0 : digit[cursor] + 4'd1;
      end else if (press[BD]) begin
        digit[cursor] <= (digit[cursor] == 4'd0) ? 4'd9 : digit[cursor] - 4'd1;
      end else if (press[BL]) begin
        cursor <= cursor - 2'd1;
      end else if (press[BR]) begin
        cursor <= cursor + 2'd1;
      end
    end
  end

  always_comb begin
    entry_value = 16'(digit[0]) * 16'd1000 + 16'(digit[1]) * 16'd100
                + 16'(digit[2]) * 16'd10 + 16'(digit[3]);
  end

endmodule

// File: tb/tb_digit_entry.sv
// Directed bench for digit_entry with DEBOUNCE_CYCLES = 4.
module tb_digit_entry;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btnU = 1'b0;
  logic        btnD = 1'b0;
  logic        btnL = 1'b0;
  logic        btnR = 1'b0;
  logic        btnC = 1'b0;
  logic [15:0] entry_value;
  logic [1:0]  cursor;
  logic        commit_valid;
  logic [15:0] commit_value;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cv_count = 0;
  int cv_last = 0;

  localparam logic [4:0] B_C = 5'b00001;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b01000;
  localparam logic [4:0] B_R = 5'b10000;

  digit_entry #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
    .clk(clk), .reset(reset),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .btnC(btnC),
    .entry_value(entry_value), .cursor(cursor),
    .commit_valid(commit_valid), .commit_value(commit_value), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (commit_valid) begin
      cv_count = cv_count + 1;
      cv_last  = int'(commit_value);
    end
  end

  task automatic drive(input logic [4:0] m);
    btnC = m[0];
    btnU = m[1];
    btnD = m[2];
    btnL = m[3];
    btnR = m[4];
  endtask

  task automatic tap(input logic [4:0] m);
    drive(m);
    repeat (20) @(negedge clk);
    drive(5'd0);
    repeat (20) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int base;
    do_reset();
    base = cv_count;
    repeat (50) @(negedge clk);
    n_cmp++; if (entry_value !== 16'd0) begin n_err++; $display("FAIL reset_entry: got %0d expected 0", entry_value); end
    n_cmp++; if (cursor !== 2'd0) begin n_err++; $display("FAIL reset_cursor: got %0d expected 0", cursor); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0d expected 0", busy); end
    n_cmp++; if (commit_value !== 16'd0) begin n_err++; $display("FAIL reset_commit_value: got %0d expected 0", commit_value); end
    n_cmp++; if (cv_count - base !== 0) begin n_err++; $display("FAIL reset_no_commit: got %0d pulses expected 0", cv_count - base); end
  endtask

  task automatic test_main();
    int lat;
    lat = -1;
    drive(B_U);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (lat < 0 && entry_value != 16'd0) lat = k;
    end
    drive(5'd0);
    repeat (20) @(negedge clk);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL press_latency: got %0d cycles expected 8", lat); end
    n_cmp++; if (entry_value !== 16'd1000) begin n_err++; $display("FAIL first_inc: got %0d expected 1000", entry_value); end
    tap(B_U);
    tap(B_U);
    n_cmp++; if (entry_value !== 16'd3000) begin n_err++; $display("FAIL three_inc: got %0d expected 3000", entry_value); end
    tap(B_R);
    n_cmp++; if (cursor !== 2'd1) begin n_err++; $display("FAIL right_once: got %0d expected 1", cursor); end
    tap(B_D);
    n_cmp++; if (entry_value !== 16'd3900) begin n_err++; $display("FAIL dec_wrap_3900: got %0d expected 3900", entry_value); end
    n_cmp++; if (cursor !== 2'd1) begin n_err++; $display("FAIL cursor_after_dec: got %0d expected 1", cursor); end
  endtask

  task automatic test_wrap();
    tap(B_U);
    n_cmp++; if (entry_value !== 16'd3000) begin n_err++; $display("FAIL inc_wrap_9_0: got %0d expected 3000", entry_value); end
    for (int i = 0; i < 9; i++) tap(B_U);
    n_cmp++; if (entry_value !== 16'd3900) begin n_err++; $display("FAIL ten_inc_same: got %0d expected 3900", entry_value); end
    tap(B_L);
    n_cmp++; if (cursor !== 2'd0) begin n_err++; $display("FAIL left_1_0: got %0d expected 0", cursor); end
    tap(B_L);
    n_cmp++; if (cursor !== 2'd3) begin n_err++; $display("FAIL left_wrap_0_3: got %0d expected 3", cursor); end
    tap(B_D);
    n_cmp++; if (entry_value !== 16'd3909) begin n_err++; $display("FAIL units_dec_wrap: got %0d expected 3909", entry_value); end
    tap(B_U);
    n_cmp++; if (entry_value !== 16'd3900) begin n_err++; $display("FAIL units_inc_wrap: got %0d expected 3900", entry_value); end
    tap(B_R);
    n_cmp++; if (cursor !== 2'd0) begin n_err++; $display("FAIL right_wrap_3_0: got %0d expected 0", cursor); end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 20; i++) begin
      btnU = ~btnU;
      repeat (2) @(negedge clk);
    end
    btnU = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (entry_value !== 16'd3900) begin n_err++; $display("FAIL glitch_entry: got %0d expected 3900", entry_value); end
    n_cmp++; if (cursor !== 2'd0) begin n_err++; $display("FAIL glitch_cursor: got %0d expected 0", cursor); end
    tap(B_U);
    n_cmp++; if (entry_value !== 16'd4900) begin n_err++; $display("FAIL steady_after_glitch: got %0d expected 4900", entry_value); end
  endtask

  task automatic test_commit();
    int base;
    do_reset();
    repeat (5) @(negedge clk);
    tap(B_U);
    tap(B_R);
    tap(B_U); tap(B_U);
    tap(B_R);
    tap(B_U); tap(B_U); tap(B_U);
    tap(B_R);
    tap(B_U); tap(B_U); tap(B_U); tap(B_U);
    n_cmp++; if (entry_value !== 16'd1234) begin n_err++; $display("FAIL setup_1234: got %0d expected 1234", entry_value); end
    base = cv_count;
    drive(B_C);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 12) btnU = 1'b1;
      if (k == 20) btnU = 1'b0;
    end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_during_hold: got %0d expected 1", busy); end
    drive(5'd0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_before_release: got %0d expected 1", busy); end
      end
      if (k == 7) begin
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after_release: got %0d expected 0", busy); end
      end
    end
    n_cmp++; if (cv_count - base !== 1) begin n_err++; $display("FAIL commit_pulse_count: got %0d expected 1", cv_count - base); end
    n_cmp++; if (cv_last !== 1234) begin n_err++; $display("FAIL commit_pulse_value: got %0d expected 1234", cv_last); end
    n_cmp++; if (commit_value !== 16'd1234) begin n_err++; $display("FAIL commit_value: got %0d expected 1234", commit_value); end
    n_cmp++; if (entry_value !== 16'd1234) begin n_err++; $display("FAIL hold_ignores_u: got %0d expected 1234", entry_value); end
    n_cmp++; if (cursor !== 2'd3) begin n_err++; $display("FAIL cursor_retained: got %0d expected 3", cursor); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = cv_count;
    drive(B_U | B_C);
    repeat (12) @(negedge clk);
    n_cmp++; if (cv_count - base !== 1) begin n_err++; $display("FAIL simul_commit_count: got %0d expected 1", cv_count - base); end
    n_cmp++; if (commit_value !== 16'd1234) begin n_err++; $display("FAIL simul_commit_value: got %0d expected 1234", commit_value); end
    n_cmp++; if (entry_value !== 16'd1234) begin n_err++; $display("FAIL simul_u_dropped: got %0d expected 1234", entry_value); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL simul_in_hold: got %0d expected 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (entry_value !== 16'd0) begin n_err++; $display("FAIL midhold_reset_entry: got %0d expected 0", entry_value); end
    n_cmp++; if (cursor !== 2'd0) begin n_err++; $display("FAIL midhold_reset_cursor: got %0d expected 0", cursor); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midhold_reset_busy: got %0d expected 0", busy); end
    n_cmp++; if (commit_value !== 16'd0) begin n_err++; $display("FAIL midhold_reset_cvalue: got %0d expected 0", commit_value); end
    reset = 1'b0;
    repeat (30) @(negedge clk);
    drive(5'd0);
    repeat (20) @(negedge clk);
    n_cmp++; if (cv_count - base !== 2) begin n_err++; $display("FAIL held_through_reset_commit: got %0d expected 2", cv_count - base); end
    n_cmp++; if (cv_last !== 0) begin n_err++; $display("FAIL held_through_reset_value: got %0d expected 0", cv_last); end
    n_cmp++; if (entry_value !== 16'd0) begin n_err++; $display("FAIL held_through_reset_entry: got %0d expected 0", entry_value); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL final_busy: got %0d expected 0", busy); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_main();
    test_wrap();
    test_glitch();
    test_commit();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
